mc_mem_unit: RTL

//   Memory-access front end for the multicycle core: owns the PC register,
//   the instruction register and the data register. It arbitrates fetch vs. load/store

---
 rtl/mc_mem_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mc_mem_unit.sv
// Memory-access front end for the multicycle core: owns PC, IR and data register and
// arbitrates fetch vs. load/store onto one req/ready memory port with timeout and alignment checks.
module mc_mem_unit #(
    parameter int                XLEN     = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15,
    parameter int                AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [XLEN-1:0]   data_wdata,
    input  logic              pc_we,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] pc,
    output logic [XLEN-1:0]   inst,
    output logic [XLEN-1:0]   read_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready
);
    localparam int BYTES = XLEN / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int CW    = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, ERR} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt;
    logic          active, xfer_done, timeout, misaligned, data_start;

    assign active     = (state == FETCH) || (state == LOAD) || (state == STORE);
    assign xfer_done  = active && mem_ready;
    assign timeout    = active && !mem_ready && (wait_cnt == CW'(MAX_WAIT - 1));
    assign misaligned = (data_addr[LSB-1:0] != '0);
    assign data_start = (state == IDLE) && !fetch_req && data_req;

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (fetch_req)
                    state_nx = FETCH;
                else if (data_req)
                    state_nx = misaligned ? ERR : (data_we ? STORE : LOAD);
            end
            FETCH, LOAD, STORE: begin
                mem_req = 1'b1;
                mem_we  = (state == STORE);
                if (mem_ready)
                    state_nx = IDLE;
                else if (timeout)
                    state_nx = ERR;
            end
            ERR: begin
                if (err_clr)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            inst      <= '0;
            read_data <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state <= state_nx;
            done  <= xfer_done;

            // Address/data are latched once at the start so the port stays stable.
            if (state == IDLE && fetch_req)
                mem_addr <= pc;
            else if (data_start && !misaligned) begin
                mem_addr  <= data_addr;
                mem_wdata <= data_wdata;
            end

            if (active && !mem_ready)
                wait_cnt <= timeout ? '0 : wait_cnt + 1'b1;
            else
                wait_cnt <= '0;

            if (state == FETCH && mem_ready)
                inst <= mem_rdata;
            if (state == LOAD && mem_ready)
                read_data <= mem_rdata;

            if (pc_we)
                pc <= pc_next;
            else if (AUTO_INC != 0 && state == FETCH && mem_ready)
                pc <= pc + ADDR_W'(BYTES);

            if ((data_start && misaligned) || timeout)
                err <= 1'b1;
            else if (state == ERR && err_clr)
                err <= 1'b0;
        end
    end
endmodule
